// File: rtl/icache_fetch.sv
// Instruction-fetch front end: PC register, direct-mapped I-cache lookup and burst line refill.
// Defining ICACHE_PERF_EN adds the hit_count / miss_count performance counter outputs.
module icache_fetch #(
    parameter int unsigned LINES    = 16,
    parameter int unsigned WORDS    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] ins,
    output logic [31:0] next_pc,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned OFF_W    = $clog2(WORDS);
    localparam int unsigned IDX_W    = $clog2(LINES);
    localparam int unsigned LINE_LSB = OFF_W + 2;
    localparam int unsigned TAG_W    = 32 - LINE_LSB - IDX_W;

    typedef enum logic [1:0] {StLookup, StReq, StFill} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [LINES-1:0] valid_q, valid_d;

    // Storage arrays carry no reset; valid_q alone qualifies their contents.
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             data_we;
    logic             tag_we;
    logic             unused_target_bits;

    assign off    = pc_q[LINE_LSB-1:2];
    assign idx    = pc_q[LINE_LSB +: IDX_W];
    assign tag    = pc_q[31 -: TAG_W];
    assign target = {branch_target[31:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        beat_d    = beat_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        valid_d   = valid_q;
        hit       = 1'b0;
        mem_req   = 1'b0;
        data_we   = 1'b0;
        tag_we    = 1'b0;

        if (state_q == StLookup) begin
            hit = valid_q[idx] && (tag_mem[idx] == tag);
        end

        // Any redirect that cannot be applied this cycle is parked; the latest one wins.
        if (branch_taken && !hit) begin
            pend_d    = 1'b1;
            pend_pc_d = target;
        end

        unique case (state_q)
            StLookup: begin
                if (hit) begin
                    if (branch_taken) begin
                        pc_d = target;
                    end else if (!stall) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = StFill;
                    beat_d  = '0;
                end
            end
            StFill: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        state_d      = StLookup;
                        pend_d       = 1'b0;
                        if (branch_taken) begin
                            pc_d = target;
                        end else if (pend_q) begin
                            pc_d = pend_pc_q;
                        end
                    end
                end
            end
            default: state_d = StLookup;
        endcase
    end

    assign ins      = hit ? data_mem[idx][off] : 32'h0;
    assign next_pc  = pc_q + 32'd4;
    assign mem_addr = mem_req ? {pc_q[31:LINE_LSB], {LINE_LSB{1'b0}}} : 32'h0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StLookup;
            pc_q      <= RESET_PC;
            beat_q    <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            beat_q    <= beat_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (data_we) begin
            data_mem[idx][beat_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[idx] <= tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else if (state_q == StLookup) begin
            if (hit && !stall) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (!hit) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus random stimulus vs a line-level model.
// Memory word at byte address A always holds 0x100 + A/4, so expected instructions follow from the PC.
module tb_icache_fetch;
    localparam int unsigned LINES      = 16;
    localparam int unsigned WORDS      = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] LINE_BYTES = WORDS * 4;
    localparam int          ModeLookup = 0;
    localparam int          ModeReq    = 1;
    localparam int          ModeFill   = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ins;
    logic [31:0] next_pc;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_fetch #(
        .LINES    (LINES),
        .WORDS    (WORDS),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ins           (ins),
        .next_pc       (next_pc),
        .hit           (hit),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: which line base address each cache index currently holds.
    int          m_mode;
    logic [31:0] m_pc;
    int          m_beat;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_lines [int];
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] word_val(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~(LINE_BYTES - 32'd1);
    endfunction

    function automatic int index_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    function automatic bit m_hit();
        return m_mode == ModeLookup && m_lines.exists(index_of(m_pc)) &&
               m_lines[index_of(m_pc)] == line_of(m_pc);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit h;
        h = m_hit();
        check_eq("hit", 32'(hit), 32'(h));
        check_eq("ins", ins, h ? word_val(m_pc) : 32'h0);
        check_eq("next_pc", next_pc, m_pc + 32'd4);
        check_eq("mem_req", 32'(mem_req), 32'(m_mode == ModeReq));
        if (m_mode == ModeReq) check_eq("mem_addr", mem_addr, line_of(m_pc));
`ifdef ICACHE_PERF_EN
        check_eq("hit_count", hit_count, m_hits);
        check_eq("miss_count", miss_count, m_misses);
`endif
    endtask

    task automatic model_reset();
        m_mode = ModeLookup;
        m_pc   = RESET_PC;
        m_beat = 0;
        m_pend = 1'b0;
        m_pend_pc = 32'h0;
        m_lines.delete();
        m_hits = 32'h0;
        m_misses = 32'h0;
    endtask

    task automatic model_clock(input bit s, input bit b, input logic [31:0] tg, input bit a,
                               input bit rv);
        logic [31:0] t;
        t = {tg[31:2], 2'b00};
        if (m_mode == ModeLookup && m_hit()) begin
            if (!s) m_hits++;
            if (b) m_pc = t;
            else if (!s) m_pc = m_pc + 32'd4;
        end else begin
            if (b) begin
                m_pend = 1'b1;
                m_pend_pc = t;
            end
            if (m_mode == ModeLookup) begin
                m_misses++;
                m_mode = ModeReq;
            end else if (m_mode == ModeReq) begin
                if (a) begin
                    m_mode = ModeFill;
                    m_beat = 0;
                end
            end else if (rv) begin
                if (m_beat == WORDS - 1) begin
                    m_lines[index_of(m_pc)] = line_of(m_pc);
                    m_mode = ModeLookup;
                    if (m_pend) m_pc = m_pend_pc;
                    m_pend = 1'b0;
                end else begin
                    m_beat++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, and check at the next falling edge.
    task automatic cycle(input bit s, input bit b, input logic [31:0] tg, input bit a, input bit rv);
        stall = s;
        branch_taken = b;
        branch_target = tg;
        mem_ack = a;
        mem_rvalid = rv;
        mem_rdata = (m_mode == ModeFill) ? word_val(line_of(m_pc) + 32'(m_beat * 4)) : $urandom;
        @(posedge CLK);
        model_clock(s, b, tg, a, rv);
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        #2;
        model_reset();
        compare_outputs();
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        compare_outputs();
    endtask

    // Hold the PC with stall while a fast memory completes any fill in progress.
    task automatic settle();
        for (int i = 0; i < 40 && !m_hit(); i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("settle_hit", 32'(hit), 32'd1);
    endtask

    initial begin
        logic [31:0] miss_base;
        #1;
        apply_reset();

        // Cold start: miss, request, four beats, hit in cycle 6.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("cold_hit", 32'(hit), 32'd1);
        check_eq("cold_ins", ins, 32'h100);
        check_eq("cold_next_pc", next_pc, 32'h4);
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            check_eq("seq_ins", ins, 32'h100 + 32'(i));
            check_eq("seq_no_req", 32'(mem_req), 32'd0);
        end

        // Line boundary at 0x10, then back to 0x0 without a refill.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("boundary_addr", mem_addr, 32'h10);
        settle();
        cycle(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        check_eq("rebranch_ins", ins, 32'h100);

        // Misaligned target, and a redirect pulse in the middle of a fill.
        cycle(1'b0, 1'b1, 32'h43, 1'b0, 1'b0);
        check_eq("target_align", next_pc, 32'h44);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h8, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("pending_ins", ins, 32'h102);
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        check_eq("revisit_ins", ins, 32'h110);

        // Stall holds PC and instruction.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("stall_ins", ins, 32'h110);
        end

        // Late acknowledge: request and address stay put.
        cycle(1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("late_ack_req", 32'(mem_req), 32'd1);
            check_eq("late_ack_addr", mem_addr, 32'h80);
        end
        settle();

        // Reset after the second beat leaves the line invalid.
        cycle(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        apply_reset();
        check_eq("mid_rst_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_pc", next_pc, RESET_PC + 32'd4);
        settle();
        cycle(1'b0, 1'b1, 32'hC0, 1'b1, 1'b1);
        check_eq("refetch_miss", 32'(hit), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("refetch_addr", mem_addr, 32'hC0);
        settle();

        // Conflicting lines evict each other on every access.
        miss_base = m_misses;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, (i % 2 == 0) ? LINES * LINE_BYTES : 32'h0, 1'b1, 1'b1);
            check_eq("conflict_miss", 32'(hit), 32'd0);
            settle();
        end
`ifdef ICACHE_PERF_EN
        check_eq("conflict_count", miss_count, miss_base + 32'd4);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                      32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Instruction-fetch stage front end. Holds the program counter, looks it up in a direct-mapped instruction cache, and presents `ins`, `next_pc` and `hit` to the IF/ID pipeline register, which captures them on the falling edge of `CLK` only when `hit` is 1. On a miss it refills one cache line from instruction memory with a request/acknowledge handshake followed by a burst of word beats.

## Interface
- `LINES`, 16: number of cache lines (power of 2, ≥2).
- `WORDS`, 4: 32-bit words per line (power of 2, ≥2).
- `RESET_PC`, 32'h0000_0000: PC value after reset (word aligned).

- `CLK`, in, 1: clock; all state updates on rising edge.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `stall`, in, 1: hazard hold; PC does not advance on a hit.
- `branch_taken`, in, 1: redirect request.
- `branch_target`, in, 32: redirect PC; bits [1:0] forced to 0.
- `ins`, out, 32: instruction at PC when `hit`=1; 0 otherwise.
- `next_pc`, out, 32: PC+4 (wraps mod 2^32).
- `hit`, out, 1: `ins` is valid this cycle.
- `mem_req`, out, 1: line-fill request; held until acknowledged.
- `mem_addr`, out, 32: line-aligned fill address; stable while `mem_req`=1.
- `mem_ack`, in, 1: request accepted.
- `mem_rvalid`, in, 1: a fill beat is present on `mem_rdata`.
- `mem_rdata`, in, 32: fill data word, ascending word order.

## Operation
- Address split: offset = pc[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits. pc[1:0] is always 0.
- FSM states:
  - LOOKUP: `hit` = valid[index] & tag match (combinational from PC/arrays).
    - Hit and `stall`=0: PC <= `branch_taken` ? target : PC+4.
    - Hit and `stall`=1: PC holds; `branch_taken` still redirects.
    - Miss: go to REQ.
  - REQ: `mem_req`=1, `mem_addr` = {PC line bits, zero offset}. `mem_ack`=1 goes to FILL with beat counter = 0.
  - FILL: each `mem_rvalid` writes `mem_rdata` into data[index][counter] and increments the counter. The last beat (counter = WORDS-1) writes the tag, sets valid[index] and returns to LOOKUP.
- Branch during REQ/FILL: target is latched as pending (last one wins). The fill completes and the line is installed. On entry to LOOKUP, PC <= pending target and pending is cleared.
- `hit`=0 in REQ and FILL. `mem_rvalid` outside FILL is ignored. `mem_ack` outside REQ is ignored.
- No invalidation other than reset; a refill overwrites the line.

## Timing
- Reset values:
  - PC = `RESET_PC`, state LOOKUP, all valid bits 0.
  - `hit`=0, `ins`=0, `next_pc`=`RESET_PC`+4.
  - `mem_req`=0, `mem_addr`=0, pending redirect cleared.
  - Data and tag arrays are not reset.
- Hit latency 0: `ins`/`hit` reflect the current PC within the same cycle, stable before the falling edge.
- Miss timeline with zero memory wait:
  - Cycle 0: LOOKUP miss.
  - Cycle 1: REQ, `mem_ack` sampled.
  - Cycles 2 to WORDS+1: FILL beats.
  - Cycle WORDS+2: LOOKUP, hit.
- Memory stalls (late `mem_ack`, gaps between beats) extend REQ/FILL one-for-one.
- `RST_N` low mid-REQ/FILL: immediate return to reset state; the partial line is left invalid. Any beats still arriving are ignored.
- Simultaneous hit, `stall`=1 and `branch_taken`=1: redirect wins.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `hit_count` and `miss_count` (32 bits each, reset 0, wrap at 2^32).
  - `hit_count` increments on each LOOKUP hit cycle where `stall`=0.
  - `miss_count` increments on each LOOKUP→REQ transition.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Cold start, `RESET_PC`=0, memory returns words 0x100+i:
  - `mem_req` with `mem_addr`=0 in cycle 1.
  - Four beats.
  - `hit`=1, `ins`=0x100, `next_pc`=4 in cycle 6.
  - Next three cycles hit at PCs 4, 8, C with no `mem_req`.
- Sequential run across a line boundary at PC 0x10: one new miss, `mem_addr`=0x10. Re-branch to 0x0: hit with no refill.
- `branch_taken`=1, target 0x43 on a hit: PC becomes 0x40. A pulse during FILL is applied after the last beat; the filled line is valid on revisit.
- `stall`=1 for 3 cycles on a hit: PC and `ins` constant, `hit` stays 1. `mem_ack` delayed 5 cycles: `mem_req`/`mem_addr` held stable throughout.
- `RST_N` low after the 2nd beat: PC=`RESET_PC`, `mem_req`=0. Re-lookup of the same line misses and refetches.
- Conflict: PCs 0x0 and LINES·WORDS·4 alternate. Each access misses; under `ICACHE_PERF_EN`, `miss_count` increments per access.
